load_align_unit: RTL and testbench
==================================

# load_align_unit

Parametrised load unit for the pipeline's MEM stage. It replaces the pass-through load-data path with a sequenced block. For each accepted load request it issues one or two aligned reads to synchronous data memory, then extracts the byte, half-word or word selected by the address offset. The result is sign- or zero-extended per `load_option` and returned over a valid/ready response channel to write-back.

## Interface
Parameters:
- `XLEN` – default 32 – data width; legal values 32 or 64.
- `ADDR_W` – default 32 – byte-address width.

Ports:
- `clk` – in – 1 – clock; all state updates on the rising edge.
- `rst` – in – 1 – reset; asynchronous, active-high.
- `req_valid` – in – 1 – load request present.
- `req_ready` – out – 1 – unit can accept a request; combinational, high only in IDLE.
- `req_addr` – in – ADDR_W – byte address.
- `req_op` – in – 3 – `load_option` encoding:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - 011 LD and 110 LWU are legal only when XLEN=64.
- `req_tag` – in – 5 – destination register tag; returned unchanged.
- `mem_rd_en` – out – 1 – memory read strobe.
- `mem_addr` – out – ADDR_W – XLEN-aligned word address.
- `mem_rdata` – in – XLEN – read data, valid exactly one cycle after `mem_rd_en`.
- `resp_valid` – out – 1 – response present.
- `resp_ready` – in – 1 – write-back accepts response.
- `resp_data` – out – XLEN – extended load result.
- `resp_tag` – out – 5 – echoed `req_tag`.
- `resp_fault` – out – 1 – illegal op, or misaligned access when misaligned support is compiled out.

## Operation
- Memory is little-endian.
- Offset: `off = req_addr[log2(XLEN/8)-1:0]`. Base address: `req_addr` with offset bits cleared.
- Size: 1, 2, 4 or 8 bytes, taken from `req_op[1:0]`.
- Spanning access: `off + size > XLEN/8`.
- States:
  - **IDLE** – `req_ready=1`. On handshake, latch addr, op and tag, then:
    - illegal op → RESP with fault;
    - spanning access without the macro → RESP with fault;
    - otherwise → ISSUE0.
  - **ISSUE0** – `mem_rd_en=1`, `mem_addr=base` → CAP0.
  - **CAP0** – capture `mem_rdata` into `w0`.
    - Spanning: `mem_rd_en=1`, `mem_addr=base+XLEN/8` (wraps modulo 2^ADDR_W) → CAP1.
    - Not spanning → RESP.
  - **CAP1** – capture into `w1` → RESP.
  - **RESP** – `resp_valid=1`. Leave for IDLE on `resp_valid & resp_ready`.
- Extraction: `({w1,w0} >> 8*off)` truncated to size. `w1=0` when the access does not span.
- Extension: LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend. LD has no extension.
- Fault responses carry `resp_data=0` and issue no memory read.
- `resp_data`, `resp_tag` and `resp_fault` are registered. They are held stable while `resp_valid & !resp_ready`.

## Timing
- Request accepted in cycle T:
  - aligned / non-spanning load: `resp_valid` at T+3;
  - spanning load: `resp_valid` at T+4;
  - fault: `resp_valid` at T+1.
- Throughput: one outstanding load. No new request is accepted in the cycle a response completes; `req_ready` rises the cycle after.
- Reset values: state=IDLE, `req_ready=1`, `mem_rd_en=0`, `mem_addr=0`, `resp_valid=0`, `resp_data=0`, `resp_tag=0`, `resp_fault=0`.
- Reset mid-operation aborts the transaction immediately and asynchronously. Read data returning after reset is ignored, and no response is produced.

## Configuration
- `LOAD_MISALIGN_EN` defined: spanning accesses run the two-read sequence ISSUE0→CAP0→CAP1.
- `LOAD_MISALIGN_EN` undefined: CAP1 and `w1` are removed, and every spanning access returns `resp_fault=1` at T+1 with no memory read.
- Misaligned accesses that do not span are always supported (e.g. LB at any offset, LH at offset 1 with XLEN=32).

## Structure
- Package `load_pkg` holds:
  - `load_op_e` with the encodings above;
  - the FSM state enum `load_state_e`;
  - a function giving byte size from the op.
- Sub-module `load_extend` is combinational and shared with other users. Inputs: `{w1,w0}`, `off`, op. Output: the extended XLEN result.
- The top module holds the FSM, request latches and response registers.

## Test plan
- **LB, negative byte:** XLEN=32, word@0x1000=0x80FF1234, LB addr 0x1003 → one read at 0x1000; `resp_data=0xFFFFFF80`, `resp_valid` at T+3.
- **LHU:** same word, LHU addr 0x1002 → `resp_data=0x000080FF`, `resp_fault=0`.
- **Spanning LW:** word@0x1000=0x44332211, word@0x1004=0x88776655, LW addr 0x1001.
  - With macro: reads at 0x1000 then 0x1004; `resp_data=0x55443322` at T+4.
  - Without macro: `resp_fault=1` at T+1, `mem_rd_en` never high.
- **Back-pressure:** hold `resp_ready=0` for 5 cycles after `resp_valid` → data and tag stable, `req_ready=0`. Release → `req_ready=1` the next cycle.
- **Illegal op:** `req_op=3'b011` at XLEN=32 → `resp_fault=1`, `resp_data=0` at T+1, no memory read.
- **Reset mid-load:** assert `rst` during CAP0 → all outputs take reset values the same cycle. A following LW at 0x1004 completes normally with 0x88776655.

Source files
------------

// File: rtl/load_pkg.sv
// Shared types and helpers for the MEM-stage load unit.
// LOAD_MISALIGN_EN adds the second-read state used by spanning accesses.
package load_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LD  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_LWU = 3'b110
  } load_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_CAP0   = 3'd2,
`ifdef LOAD_MISALIGN_EN
    ST_CAP1   = 3'd4,
`endif
    ST_RESP   = 3'd3
  } load_state_e;

  // Access size in bytes: 1, 2, 4 or 8 from the low two op bits.
  function automatic logic [3:0] op_size_bytes(input logic [2:0] op);
    return 4'd1 << op[1:0];
  endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/half/word/double from a two-word window and
// sign- or zero-extends it to XLEN.
module load_extend
  import load_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0]         dword_i,
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [2:0]                op_i,
  output logic [XLEN-1:0]           result_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            msb;

  always_comb begin
    shifted = XLEN'(dword_i >> {off_i, 3'b000});
    keep    = '1;
    msb     = 1'b0;
    case (op_size_bytes(op_i))
      4'd1: begin keep = XLEN'(8'hFF);         msb = shifted[7];  end
      4'd2: begin keep = XLEN'(16'hFFFF);      msb = shifted[15]; end
      4'd4: begin keep = XLEN'(32'hFFFF_FFFF); msb = shifted[31]; end
      default: ;
    endcase
    // op bit 2 selects the unsigned variants
    result_o = (shifted & keep) | (~keep & {XLEN{msb & ~op_i[2]}});
  end

endmodule

// File: rtl/load_align_unit.sv
// Sequenced MEM-stage load unit: one or two aligned reads, extract, extend.
// Define LOAD_MISALIGN_EN to support loads that span two memory words.
module load_align_unit
  import load_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_tag,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [4:0]        resp_tag,
  output logic              resp_fault
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);
`ifdef LOAD_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_legal = 1'b1;
      OP_LD, OP_LWU:                       op_legal = (XLEN == 64);
      default:                             op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic spans(input logic [OFF_W-1:0] off, input logic [2:0] op);
    return (5'(off) + 5'(op_size_bytes(op))) > 5'(NBYTES);
  endfunction

  load_state_e       state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        tag_q, tag_d;
  logic [XLEN-1:0]   w0_q, w0_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic [4:0]        resp_tag_q, resp_tag_d;
  logic              resp_fault_q, resp_fault_d;
  logic              fin;
  logic              span_req;
  logic [XLEN-1:0]   w0, w1, ext_data;

  assign span_req = spans(req_addr[OFF_W-1:0], req_op);

  // The word being captured this cycle feeds extraction directly.
  assign w0 = (state_q == ST_CAP0) ? mem_rdata : w0_q;
`ifdef LOAD_MISALIGN_EN
  logic span_cur;
  assign span_cur = spans(off_q, op_q);
  assign w1       = (state_q == ST_CAP1) ? mem_rdata : '0;
`else
  assign w1 = '0;
`endif

  load_extend #(.XLEN(XLEN)) u_extend (
    .dword_i  ({w1, w0}),
    .off_i    (off_q),
    .op_i     (op_q),
    .result_o (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      off_q        <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      w0_q         <= '0;
      rd_en_q      <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      w0_q         <= w0_d;
      rd_en_q      <= rd_en_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    op_d         = op_q;
    tag_d        = tag_q;
    w0_d         = w0_q;
    rd_en_d      = 1'b0;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    resp_fault_d = resp_fault_q;
    fin          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          off_d = req_addr[OFF_W-1:0];
          op_d  = req_op;
          tag_d = req_tag;
          if (!op_legal(req_op) || (span_req && !MISALIGN_EN)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
            resp_tag_d   = req_tag;
            resp_fault_d = 1'b1;
          end else begin
            state_d    = ST_ISSUE0;
            rd_en_d    = 1'b1;
            mem_addr_d = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          end
        end
      end
      ST_ISSUE0: begin
        state_d = ST_CAP0;
`ifdef LOAD_MISALIGN_EN
        // Second read goes out while the first word is being captured.
        if (span_cur) begin
          rd_en_d    = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(NBYTES);
        end
`endif
      end
      ST_CAP0: begin
        w0_d = mem_rdata;
`ifdef LOAD_MISALIGN_EN
        if (span_cur) state_d = ST_CAP1;
        else          fin     = 1'b1;
`else
        fin = 1'b1;
`endif
      end
`ifdef LOAD_MISALIGN_EN
      ST_CAP1: fin = 1'b1;
`endif
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fin) begin
      state_d      = ST_RESP;
      resp_valid_d = 1'b1;
      resp_data_d  = ext_data;
      resp_tag_d   = tag_q;
      resp_fault_d = 1'b0;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (XLEN=32): vector table plus reset and
// back-pressure sequences; expectations follow LOAD_MISALIGN_EN.
module tb_load_align_unit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_op;
  logic [4:0]        req_tag;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_rdata;
  logic              resp_valid, resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic [4:0]        resp_tag;
  logic              resp_fault;

  int total = 0;
  int bad   = 0;

  load_align_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_fault (resp_fault)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data one cycle after the strobe; every read is logged.
  logic [31:0] mem [0:63];
  logic [31:0] rd_log [0:255];
  int unsigned rd_total = 0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata               <= mem[mem_addr[7:2]];
      rd_log[rd_total[7:0]]   <= mem_addr;
      rd_total                <= rd_total + 1;
    end
  end

  typedef struct {
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] addr;
    logic [2:0]  op;
    logic [4:0]  tag;
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          nrd;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] m0, input logic [31:0] m1,
                              input logic [31:0] addr, input logic [2:0] op,
                              input logic [4:0] tag, input logic [31:0] data,
                              input logic fault, input int lat, input int nrd,
                              input logic [31:0] a0, input logic [31:0] a1);
    vec_t v;
    v.m0 = m0; v.m1 = m1; v.addr = addr; v.op = op; v.tag = tag;
    v.data = data; v.fault = fault; v.lat = lat; v.nrd = nrd; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_load(input vec_t v, input int hold, input string nm);
    int lat;
    int base;
    mem[0] = v.m0;
    mem[1] = v.m1;
    check({nm, " req_ready idle"}, 64'(req_ready), 64'(1));
    req_addr  = v.addr;
    req_op    = v.op;
    req_tag   = v.tag;
    req_valid = 1'b1;
    base      = int'(rd_total);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(v.lat));
    check({nm, " data"}, 64'(resp_data), 64'(v.data));
    check({nm, " fault"}, 64'(resp_fault), 64'(v.fault));
    check({nm, " tag"}, 64'(resp_tag), 64'(v.tag));
    check({nm, " reads"}, 64'(int'(rd_total) - base), 64'(v.nrd));
    if (v.nrd > 0) check({nm, " addr0"}, 64'(rd_log[8'(base)]), 64'(v.a0));
    if (v.nrd > 1) check({nm, " addr1"}, 64'(rd_log[8'(base + 1)]), 64'(v.a1));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({nm, " hold valid"}, 64'(resp_valid), 64'(1));
      check({nm, " hold data"}, 64'(resp_data), 64'(v.data));
      check({nm, " hold tag"}, 64'(resp_tag), 64'(v.tag));
      check({nm, " hold req_ready"}, 64'(req_ready), 64'(0));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check({nm, " valid drop"}, 64'(resp_valid), 64'(0));
    check({nm, " req_ready back"}, 64'(req_ready), 64'(1));
  endtask

  vec_t tv [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_op     = '0;
    req_tag    = '0;
    resp_ready = 1'b0;

    tv[0]  = mk(32'h80FF1234, 32'h0, 32'h1003, 3'b000, 5'd1,  32'hFFFFFF80, 1'b0, 3, 1, 32'h1000, 32'h0);
    tv[1]  = mk(32'h80FF1234, 32'h0, 32'h1002, 3'b101, 5'd2,  32'h000080FF, 1'b0, 3, 1, 32'h1000, 32'h0);
    tv[2]  = mk(32'h80FF1234, 32'h0, 32'h1000, 3'b010, 5'd3,  32'h80FF1234, 1'b0, 3, 1, 32'h1000, 32'h0);
    tv[3]  = mk(32'h80FF1234, 32'h0, 32'h1001, 3'b001, 5'd4,  32'hFFFFFF12, 1'b0, 3, 1, 32'h1000, 32'h0);
    tv[4]  = mk(32'h80FF1234, 32'h0, 32'h1003, 3'b100, 5'd5,  32'h00000080, 1'b0, 3, 1, 32'h1000, 32'h0);
    tv[5]  = mk(32'h80FF1234, 32'h0, 32'h1000, 3'b000, 5'd6,  32'h00000034, 1'b0, 3, 1, 32'h1000, 32'h0);
    tv[6]  = mk(32'h80FF1234, 32'h0, 32'h1002, 3'b001, 5'd7,  32'hFFFF80FF, 1'b0, 3, 1, 32'h1000, 32'h0);
`ifdef LOAD_MISALIGN_EN
    tv[7]  = mk(32'h44332211, 32'h88776655, 32'h1001, 3'b010, 5'd8,  32'h55443322, 1'b0, 4, 2, 32'h1000, 32'h1004);
    tv[8]  = mk(32'h44332211, 32'h88776655, 32'h1003, 3'b101, 5'd9,  32'h00005544, 1'b0, 4, 2, 32'h1000, 32'h1004);
    tv[9]  = mk(32'h44332211, 32'h887766D5, 32'h1003, 3'b001, 5'd10, 32'hFFFFD544, 1'b0, 4, 2, 32'h1000, 32'h1004);
    tv[15] = mk(32'h44332211, 32'h88776655, 32'h1003, 3'b010, 5'd16, 32'h77665544, 1'b0, 4, 2, 32'h1000, 32'h1004);
`else
    tv[7]  = mk(32'h44332211, 32'h88776655, 32'h1001, 3'b010, 5'd8,  32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    tv[8]  = mk(32'h44332211, 32'h88776655, 32'h1003, 3'b101, 5'd9,  32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    tv[9]  = mk(32'h44332211, 32'h887766D5, 32'h1003, 3'b001, 5'd10, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    tv[15] = mk(32'h44332211, 32'h88776655, 32'h1003, 3'b010, 5'd16, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
`endif
    tv[10] = mk(32'h44332211, 32'h88776655, 32'h1004, 3'b010, 5'd11, 32'h88776655, 1'b0, 3, 1, 32'h1004, 32'h0);
    tv[11] = mk(32'h44332211, 32'h88776655, 32'h1000, 3'b011, 5'd12, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    tv[12] = mk(32'h44332211, 32'h88776655, 32'h1000, 3'b110, 5'd13, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    tv[13] = mk(32'h44332211, 32'h88776655, 32'h1000, 3'b111, 5'd14, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
    tv[14] = mk(32'h44332211, 32'h88776655, 32'h1007, 3'b000, 5'd15, 32'hFFFFFF88, 1'b0, 3, 1, 32'h1004, 32'h0);

    // Reset values
    #2;
    check("rst req_ready",  64'(req_ready),  64'(1));
    check("rst mem_rd_en",  64'(mem_rd_en),  64'(0));
    check("rst mem_addr",   64'(mem_addr),   64'(0));
    check("rst resp_valid", 64'(resp_valid), 64'(0));
    check("rst resp_data",  64'(resp_data),  64'(0));
    check("rst resp_tag",   64'(resp_tag),   64'(0));
    check("rst resp_fault", 64'(resp_fault), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) run_load(tv[i], 0, $sformatf("vec%0d", i));

    // Back-pressure: response held for five cycles
    run_load(tv[0], 5, "bp");

    // Reset asserted while the first word is being captured
    mem[0]    = 32'h11112222;
    req_addr  = 32'h1000;
    req_op    = 3'b010;
    req_tag   = 5'd21;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst req_ready",  64'(req_ready),  64'(1));
    check("midrst mem_rd_en",  64'(mem_rd_en),  64'(0));
    check("midrst mem_addr",   64'(mem_addr),   64'(0));
    check("midrst resp_valid", 64'(resp_valid), 64'(0));
    check("midrst resp_data",  64'(resp_data),  64'(0));
    check("midrst resp_tag",   64'(resp_tag),   64'(0));
    check("midrst resp_fault", 64'(resp_fault), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("midrst no resp", 64'(resp_valid), 64'(0));
    end
    run_load(tv[10], 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
